// File: rtl/mips_regfile_sb.sv
// 32x32 MIPS register file with registered reads, write-through bypass and a
// single-bit-per-register busy scoreboard that drives the issue stall.
module mips_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_nxt_s;
  logic [DATA_W-1:0] rd_data_a_r;
  logic [DATA_W-1:0] rd_data_b_r;
  logic              wr_ok_s;
  logic              resv_ok_s;
  logic              busy_a_s;
  logic              busy_b_s;
  logic              stall_s;

  // Next read value: r0 reads zero, a same-cycle write is forwarded.
  function automatic logic [DATA_W-1:0] rd_next(
    input logic [ADDR_W-1:0] addr,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (addr == {ADDR_W{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else if (wen && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write qualification, busy lookup with write-back override, issue gating.
  always_comb begin
    wr_ok_s   = wr_en && (wr_addr != {ADDR_W{1'b0}});
    busy_a_s  = (rd_addr_a != {ADDR_W{1'b0}}) && busy_r[rd_addr_a] &&
                !(wr_en && (wr_addr == rd_addr_a));
    busy_b_s  = (rd_addr_b != {ADDR_W{1'b0}}) && busy_r[rd_addr_b] &&
                !(wr_en && (wr_addr == rd_addr_b));
    stall_s   = busy_a_s || busy_b_s;
    resv_ok_s = resv_en && !stall_s && (resv_addr != {ADDR_W{1'b0}});
  end

  // Scoreboard update; a new reservation outranks a retiring write-back.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 1; i < DEPTH; i++) begin
      busy_nxt_s[i] = (resv_ok_s && (resv_addr == ADDR_W'(i))) ? 1'b1 :
                      (wr_ok_s && (wr_addr == ADDR_W'(i)))     ? 1'b0 :
                      busy_r[i];
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Register array storage; r0 is never written and stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Registered read ports and busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_r <= {DATA_W{1'b0}};
      rd_data_b_r <= {DATA_W{1'b0}};
      busy_r      <= {DEPTH{1'b0}};
    end else begin
      rd_data_a_r <= rd_next(rd_addr_a, wr_en, wr_addr, wr_data, regs_r[rd_addr_a]);
      rd_data_b_r <= rd_next(rd_addr_b, wr_en, wr_addr, wr_data, regs_r[rd_addr_b]);
      busy_r      <= busy_nxt_s;
    end
  end

  assign rd_data_a = rd_data_a_r;
  assign rd_data_b = rd_data_b_r;
  assign busy_a    = busy_a_s;
  assign busy_b    = busy_b_s;
  assign stall     = stall_s;

endmodule
